// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: 1 ms prescaler, two button debouncers, and the
// run/stop/lap sequencing FSM with lap snapshot display mux.
//
//   state | meaning
//   IDLE  | stopped and cleared, live value displayed
//   RUN   | counter enabled, live value displayed
//   STOP  | counter halted, live value displayed
//   LAP   | counter enabled, frozen snapshot displayed
module stopwatch_ctrl #(
    parameter int DIV    = 16,
    parameter int DEB_MS = 20
) (
    input  logic       I_CLK,
    input  logic       I_RSTN,
    input  logic       I_BTN_START,
    input  logic       I_BTN_CLEAR,
    input  logic [9:0] I_TIMER_MS,
    input  logic [5:0] I_TIMER_SEC,
    output logic       O_EN_1MS,
    output logic       O_START_EN,
    output logic       O_CLEAR_EN,
    output logic [9:0] O_DISP_MS,
    output logic [5:0] O_DISP_SEC,
    output logic       O_LAP_VALID,
    output logic [1:0] O_STATE
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (DEB_MS > 0) ? $clog2(DEB_MS + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    logic [PW-1:0] pre_cnt;
    logic [1:0]    raw;
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [1:0]    press;
    logic [CW-1:0] run_cnt [2];
    logic          start_p;
    logic          clear_p;
    state_t        state;
    state_t        state_nxt;
    logic          clear_nxt;
    logic          snap_load;
    logic [9:0]    snap_ms;
    logic [5:0]    snap_sec;

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            pre_cnt  <= '0;
            O_EN_1MS <= 1'b0;
        end else if (pre_cnt == PW'(DIV - 1)) begin
            pre_cnt  <= '0;
            O_EN_1MS <= 1'b1;
        end else begin
            pre_cnt  <= pre_cnt + PW'(1);
            O_EN_1MS <= 1'b0;
        end
    end

    assign raw = {I_BTN_CLEAR, I_BTN_START};

    // Index 0 is START, index 1 is CLEAR.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            sync_a   <= '0;
            sync_b   <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 2; i++) run_cnt[i] <= '0;
        end else begin
            sync_a   <= raw;
            sync_b   <= sync_a;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (O_EN_1MS) begin
                    if (sync_b[i] != stable[i]) begin
                        if (run_cnt[i] == CW'(DEB_MS - 1)) begin
                            stable[i]  <= sync_b[i];
                            run_cnt[i] <= '0;
                        end else begin
                            run_cnt[i] <= run_cnt[i] + CW'(1);
                        end
                    end else begin
                        run_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign press   = stable & ~stable_d;
    assign start_p = press[0];
    assign clear_p = press[1];

    // Start has priority, so every clear action is gated by !start_p.
    always_comb begin
        state_nxt = state;
        clear_nxt = 1'b0;
        snap_load = 1'b0;
        case (state)
            IDLE: begin
                if (start_p)      state_nxt = RUN;
                else if (clear_p) clear_nxt = 1'b1;
            end
            RUN: begin
                if (start_p) begin
                    state_nxt = STOP;
                end else if (clear_p) begin
                    state_nxt = LAP;
                    snap_load = 1'b1;
                end
            end
            LAP: begin
                if (start_p)      state_nxt = STOP;
                else if (clear_p) state_nxt = RUN;
            end
            STOP: begin
                if (start_p) begin
                    state_nxt = RUN;
                end else if (clear_p) begin
                    state_nxt = IDLE;
                    clear_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            state      <= IDLE;
            O_CLEAR_EN <= 1'b0;
            snap_ms    <= '0;
            snap_sec   <= '0;
        end else begin
            state      <= state_nxt;
            O_CLEAR_EN <= clear_nxt;
            if (snap_load) begin
                snap_ms  <= I_TIMER_MS;
                snap_sec <= I_TIMER_SEC;
            end
        end
    end

    assign O_STATE     = state;
    assign O_START_EN  = (state == RUN) || (state == LAP);
    assign O_LAP_VALID = (state == LAP);
    assign O_DISP_MS   = O_LAP_VALID ? snap_ms  : I_TIMER_MS;
    assign O_DISP_SEC  = O_LAP_VALID ? snap_sec : I_TIMER_SEC;

endmodule
